// File: rtl/epsilon_greedy_selector_if.sv
// Handshake and data bundle between the Q-learning controller and the
// epsilon-greedy action selector.
interface epsilon_greedy_selector_if #(
  parameter int NUM_ACT = 15,
  parameter int Q_W     = 16
) ();
  logic                   start;
  logic [NUM_ACT*Q_W-1:0] q_vec;
  logic [15:0]            epsilon;
  logic                   seed_load;
  logic [15:0]            seed;
  logic                   busy;
  logic                   done;
  logic [3:0]             action;
  logic [Q_W-1:0]         q_sel;
  logic                   explored;

  modport master (
    output start, q_vec, epsilon, seed_load, seed,
    input  busy, done, action, q_sel, explored
  );

  modport slave (
    input  start, q_vec, epsilon, seed_load, seed,
    output busy, done, action, q_sel, explored
  );
endinterface

// File: rtl/epsilon_greedy_selector.sv
// Epsilon-greedy action selector: one LFSR draw against epsilon picks either
// a sequential signed argmax over the latched Q-values or a uniformly random
// action via rejection sampling of the LFSR low nibble.
//
// state | meaning
// IDLE  | waiting for start; seed_load accepted here
// DRAW  | compare LFSR to epsilon, choose exploit or explore
// SCAN  | one signed compare per cycle, lowest index wins ties
// RAND  | draw LFSR nibble, retry until it is a legal action
// DONE  | one-cycle done pulse, results already registered
module epsilon_greedy_selector #(
  parameter int          NUM_ACT   = 15,
  parameter int          Q_W       = 16,
  parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  epsilon_greedy_selector_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, DRAW, SCAN, RAND, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ACT - 1);
  localparam logic [4:0] NUM_ACT5 = 5'(NUM_ACT);

  state_t                state_q, state_d;
  logic signed [Q_W-1:0] q_q [NUM_ACT];
  logic [15:0]           eps_q;
  logic [15:0]           lfsr_q, lfsr_d, lfsr_adv;
  logic [3:0]            idx_q, idx_d;
  logic [3:0]            best_idx_q, best_idx_d;
  logic signed [Q_W-1:0] best_q, best_d;
  logic                  explore_q, explore_d;
  logic                  latch_en;
  logic [3:0]            cand;
  logic signed [Q_W-1:0] scan_val, cand_val;
  logic [3:0]            action_q;
  logic [Q_W-1:0]        q_sel_q;
  logic                  explored_q;

  assign lfsr_adv = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign cand     = lfsr_q[3:0];

  // Read-muxes for the scan index and the random candidate; the candidate
  // may be out of range, in which case its value is never used.
  always_comb begin
    scan_val = '0;
    cand_val = '0;
    for (int k = 0; k < NUM_ACT; k++) begin
      if (idx_q == 4'(k)) scan_val = q_q[k];
      if (cand == 4'(k))  cand_val = q_q[k];
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_d     = best_q;
    explore_d  = explore_q;
    latch_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          latch_en = 1'b1;
          state_d  = DRAW;
        end else if (bus.seed_load) begin
          lfsr_d = (bus.seed == 16'h0000) ? LFSR_INIT : bus.seed;
        end
      end
      DRAW: begin
        explore_d = (lfsr_q <= eps_q);
        lfsr_d    = lfsr_adv;
        if (lfsr_q <= eps_q) begin
          state_d = RAND;
        end else begin
          state_d    = SCAN;
          idx_d      = 4'd1;
          best_d     = q_q[0];
          best_idx_d = 4'd0;
        end
      end
      SCAN: begin
        if (scan_val > best_q) begin
          best_d     = scan_val;
          best_idx_d = idx_q;
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      RAND: begin
        lfsr_d = lfsr_adv;
        if ({1'b0, cand} < NUM_ACT5) begin
          best_idx_d = cand;
          best_d     = cand_val;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state, LFSR and scan registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lfsr_q     <= LFSR_INIT;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_q     <= '0;
      explore_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_q     <= best_d;
      explore_q  <= explore_d;
    end
  end

  // Operand capture at start so later q_vec/epsilon changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eps_q <= '0;
      for (int k = 0; k < NUM_ACT; k++) q_q[k] <= '0;
    end else if (latch_en) begin
      eps_q <= bus.epsilon;
      for (int k = 0; k < NUM_ACT; k++) q_q[k] <= bus.q_vec[k*Q_W +: Q_W];
    end
  end

  // Result registers load on the edge entering DONE so they are valid
  // alongside the done pulse and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      action_q   <= '0;
      q_sel_q    <= '0;
      explored_q <= 1'b0;
    end else if (state_d == DONE && state_q != DONE) begin
      action_q   <= best_idx_d;
      q_sel_q    <= best_d;
      explored_q <= explore_d;
    end
  end

  assign bus.done     = (state_q == DONE);
  assign bus.busy     = (state_q == DRAW) || (state_q == SCAN) || (state_q == RAND);
  assign bus.action   = action_q;
  assign bus.q_sel    = q_sel_q;
  assign bus.explored = explored_q;

endmodule

// File: tb/tb_epsilon_greedy_selector.sv
// Directed bench for the epsilon-greedy selector with a small LFSR/selection
// reference model for the exploration path.
module tb_epsilon_greedy_selector;

  logic clk;
  logic rst_n;

  epsilon_greedy_selector_if #(.NUM_ACT(15), .Q_W(16)) bus ();

  epsilon_greedy_selector #(.NUM_ACT(15), .Q_W(16), .LFSR_INIT(16'hACE1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int done_cnt = 0;

  logic [15:0] m;          // reference LFSR
  logic [15:0] tq [15];    // Q-values currently driven
  logic [3:0]  last_act;
  logic [14:0] seen;
  logic [3:0]  seq_a [8];

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] adv(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic apply_q();
    for (int k = 0; k < 15; k++) bus.q_vec[k*16 +: 16] = tq[k];
  endtask

  task automatic seed_ld(input logic [15:0] s);
    bus.seed_load = 1'b1;
    bus.seed      = s;
    @(posedge clk); #1;
    bus.seed_load = 1'b0;
    m = (s == 16'h0000) ? 16'hACE1 : s;
  endtask

  // One selection; gact/gq are the hand-computed argmax results used when
  // the model says the draw exploits.
  task automatic sel(input string tag, input logic [15:0] eps, input logic [3:0] gact,
                     input bit scramble);
    logic       ex;
    logic [3:0] c;
    logic [3:0] ea;
    int         rej, lat, exp_lat;
    ex  = (m <= eps);
    m   = adv(m);
    rej = 0;
    if (ex) begin
      c = m[3:0];
      m = adv(m);
      while (c == 4'd15) begin
        rej++;
        c = m[3:0];
        m = adv(m);
      end
      ea      = c;
      exp_lat = 3 + rej;
    end else begin
      ea      = gact;
      exp_lat = 16;
    end
    bus.epsilon = eps;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.seed_load = 1'b0;
    if (scramble) bus.q_vec = ~bus.q_vec;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"},      lat,          exp_lat);
    chk({tag, "_action"},   bus.action,   ea);
    chk({tag, "_q_sel"},    bus.q_sel,    tq[ea]);
    chk({tag, "_explored"}, bus.explored, ex);
    chk({tag, "_busy"},     bus.busy,     1'b0);
    last_act = bus.action;
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, bus.done, 1'b0);
    if (scramble) apply_q();
  endtask

  initial begin
    int snap, got, cyc, prev;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed      = 16'h0000;
    bus.epsilon   = 16'h0000;
    bus.q_vec     = '0;
    m             = 16'hACE1;
    seen          = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_action",   bus.action,   4'd0);
    chk("rst_q_sel",    bus.q_sel,    16'h0000);
    chk("rst_explored", bus.explored, 1'b0);

    // Greedy argmax, with q_vec scrambled after start
    for (int k = 0; k < 15; k++) tq[k] = 16'(k * 16'h0100);
    tq[9] = 16'h7FFF;
    apply_q();
    sel("greedy", 16'h0000, 4'd9, 1'b1);

    // Signed compare and tie-break
    for (int k = 0; k < 15; k++) tq[k] = 16'hFF00;
    tq[3] = 16'h0080; tq[11] = 16'h0080;
    apply_q();
    sel("tie", 16'h0000, 4'd3, 1'b0);
    for (int k = 0; k < 15; k++) tq[k] = 16'h8000;
    apply_q();
    sel("alleq", 16'h0000, 4'd0, 1'b0);
    for (int k = 0; k < 15; k++) tq[k] = 16'h0000;
    tq[14] = 16'h0001; tq[7] = 16'h8001;
    apply_q();
    sel("last", 16'h0000, 4'd14, 1'b0);

    // Epsilon threshold boundary: equal explores, one below exploits
    seed_ld(16'h4000);
    sel("eps_eq", 16'h4000, 4'd14, 1'b0);
    chk("eps_eq_explore", bus.explored, 1'b1);
    seed_ld(16'h4000);
    sel("eps_lt", 16'h3FFF, 4'd14, 1'b0);
    chk("eps_lt_exploit", bus.explored, 1'b0);

    // Always explore
    for (int k = 0; k < 15; k++) tq[k] = 16'(16'h0101 * (k + 1));
    apply_q();
    for (int i = 0; i < 1000; i++) begin
      sel("explore", 16'hFFFF, 4'd0, 1'b0);
      chk("explore_range", {31'd0, last_act < 4'd15}, 32'd1);
      if (last_act < 4'd15) seen[last_act] = 1'b1;
    end
    chk("explore_cover", seen, 15'h7FFF);

    // Seed 0 restarts the power-up sequence
    seed_ld(16'h0000);
    for (int i = 0; i < 6; i++) sel("seed0", 16'hFFFF, 4'd0, 1'b0);

    // Same seed twice gives the same sequence
    seed_ld(16'h1234);
    for (int i = 0; i < 8; i++) begin
      sel("seedA", 16'hFFFF, 4'd0, 1'b0);
      seq_a[i] = last_act;
    end
    seed_ld(16'h1234);
    for (int i = 0; i < 8; i++) begin
      sel("seedB", 16'hFFFF, 4'd0, 1'b0);
      chk("seed_repeat", last_act, seq_a[i]);
    end

    // seed_load together with start: seed ignored
    bus.seed_load = 1'b1;
    bus.seed      = 16'h5A5A;
    sel("seed_start", 16'hFFFF, 4'd0, 1'b0);

    // Reset in the middle of a scan
    for (int k = 0; k < 15; k++) tq[k] = 16'(k * 16'h0100);
    tq[9] = 16'h7FFF;
    apply_q();
    bus.epsilon = 16'h0000;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    snap  = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",     bus.busy,     1'b0);
    chk("midrst_action",   bus.action,   4'd0);
    chk("midrst_q_sel",    bus.q_sel,    16'h0000);
    chk("midrst_explored", bus.explored, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt - snap, 0);
    m = 16'hACE1;
    for (int i = 0; i < 6; i++) sel("post_rst", 16'hFFFF, 4'd0, 1'b0);

    // start pulsed while busy is not queued
    for (int k = 0; k < 15; k++) tq[k] = 16'(k * 16'h0100);
    tq[9] = 16'h7FFF;
    apply_q();
    snap = done_cnt;
    bus.epsilon = 16'h0000;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    m = adv(m);
    repeat (40) @(posedge clk);
    #1;
    chk("busy_start_dones", done_cnt - snap, 1);
    chk("busy_start_action", bus.action, 4'd9);

    // start held high: back-to-back selections, 17-cycle period
    bus.start = 1'b1;
    got  = 0;
    cyc  = 0;
    prev = -1;
    while (got < 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done === 1'b1) begin
        m = adv(m);
        chk("held_action", bus.action, 4'd9);
        if (prev >= 0) chk("held_period", cyc - prev, 17);
        prev = cyc;
        got++;
        if (got == 3) bus.start = 1'b0;
      end
    end
    chk("held_count", got, 3);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("held_idle", bus.busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/epsilon_greedy_selector.md
Name: epsilon_greedy_selector

Overview:
- Upstream action-selection stage for the Q-learning accelerator.
- Takes the 15 action Q-values read out for the current state and picks the action to apply.
- Exploits (argmax) or explores (pseudo-random action), controlled by an LFSR draw against an epsilon threshold.
- Output action drives the accelerator's 4-bit action input: RAM-bank write decode and old-Q mux select.

Parameters:
- NUM_ACT, 15, number of actions; legal action codes are 0..NUM_ACT-1.
- Q_W, 16, Q-value width; signed two's complement (Q8.8).
- LFSR_INIT, 16'hACE1, LFSR reset and default seed value; must be nonzero.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a selection; sampled only in IDLE.
- q_vec  in  NUM_ACT*Q_W  flattened Q-values; action k occupies bits [k*Q_W +: Q_W].
- epsilon  in  16  explore threshold, unsigned; sampled with start.
- seed_load  in  1  load LFSR from seed; accepted only in IDLE.
- seed  in  16  LFSR seed; value 0 loads LFSR_INIT.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; action, q_sel and explored are valid from this cycle.
- action  out  4  selected action, held until the next done.
- q_sel  out  Q_W  Q-value of the selected action, held.
- explored  out  1  1 = random action, 0 = argmax; held.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy=0, done=0, action=0, q_sel=0, explored=0, LFSR=LFSR_INIT. Reset mid-operation aborts the selection with no done.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0. Advances only in DRAW and RAND. Never zero.
- FSM states: IDLE, DRAW, SCAN, RAND, DONE.
- IDLE:
  - start=1 at edge E0: latch q_vec and epsilon, go to DRAW, busy=1.
  - seed_load=1 with start=0: load LFSR.
  - start and seed_load high together: start wins and the seed is ignored.
- DRAW (edge E1):
  - explore iff current LFSR value <= latched epsilon. epsilon=0 never explores; epsilon=16'hFFFF always explores.
  - LFSR advances.
  - Exploit: go to SCAN with idx=1, best=q[0], best_idx=0.
  - Explore: go to RAND.
- SCAN:
  - Each edge compares q[idx] to best, signed strict greater-than; ties keep the lower index. Then idx increments.
  - After idx=NUM_ACT-1 is processed (edge E15 for 15 actions), go to DONE.
- RAND:
  - Candidate = LFSR[3:0]; LFSR advances.
  - Candidate < NUM_ACT: best_idx=candidate, best=q[candidate], go to DONE.
  - Otherwise stay in RAND and retry on the next edge (rejection sampling, no modulo bias).
- DONE:
  - Registers action=best_idx, q_sel=best, explored; done=1 for exactly one cycle; busy drops with done; return to IDLE.
  - start is sampled again in the cycle after done.
- Latency from start sampled (E0) to done high:
  - exploit: 16 cycles (done sampled high at edge E16).
  - explore: 3 cycles plus 1 per rejection.
- start while busy is ignored, not queued. q_vec and epsilon changes after E0 have no effect.
- Outputs change only at DONE or reset.

Test Plan:
- Reset: assert rst_n=0 mid-SCAN → busy=0, done never pulses, action=0, q_sel=0, explored=0; next selection is bit-identical to one run from power-up.
- Greedy argmax: epsilon=0, q[k]=k*16'h0100 except q[9]=16'h7FFF → done exactly 16 cycles after start; action=9, q_sel=16'h7FFF, explored=0.
- Signed values and ties: epsilon=0, all q=16'hFF00 (-1.0), q[3]=q[11]=16'h0080 → action=3, q_sel=16'h0080; all-equal vector → action=0.
- Always explore: epsilon=16'hFFFF, 1000 selections → explored=1 every time; action always in 0..14; each action seen at least once; matches a reference-model LFSR sequence including rejections of nibble 15.
- Seeding: seed_load with seed=0 → sequence identical to reset; seed=16'h1234 twice → identical action sequences; seed_load together with start → seed ignored.
- Handshake: start pulsed during busy → no extra done; start held high continuously → back-to-back selections, one done per selection, IDLE visited one cycle each.
